// File: rtl/fifo_pn_if.sv
// Handshake bundle between the PI register decoder (master) and the mailbox FIFO (slave).
interface fifo_pn_if #(
    parameter int DW = 8,
    parameter int AW = 11
) ();
    logic          wr_req;
    logic [DW-1:0] wr_data;
    logic          rd_req;
    logic [DW-1:0] rd_data;
    logic          flush;
    logic          clr_err;
    logic          empty;
    logic          full;
    logic          afull;
    logic [AW:0]   level;
    logic          ovf;
    logic          udf;

    modport master (
        output wr_req, wr_data, rd_req, flush, clr_err,
        input  rd_data, empty, full, afull, level, ovf, udf
    );

    modport slave (
        input  wr_req, wr_data, rd_req, flush, clr_err,
        output rd_data, empty, full, afull, level, ovf, udf
    );
endinterface

// File: rtl/fifo_pn.sv
// Parametrised show-ahead mailbox FIFO, state updated on the falling clock edge.
// Optional FIFO_PN_EDGE_SYNC_EN turns wr_req/rd_req into raw bus enables that are synchronised and edge-detected.
module fifo_pn #(
    parameter int DW        = 8,
    parameter int AW        = 11,
    parameter int AFULL_LVL = 2**AW - 16
) (
    input  logic     clk,
    input  logic     rst,
    fifo_pn_if.slave bus
);
    localparam int          DEPTH   = 2**AW;
    localparam logic [AW:0] AFULL_V = AFULL_LVL[AW:0];

    logic          wr_stb;
    logic          rd_stb;
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [AW:0]   rd_ptr_next;
    logic [AW:0]   level;
    logic          full;
    logic          out_vld;
    logic          wr_acc;
    logic          rd_acc;
    logic          set_ovf;
    logic          set_udf;
    logic          ovf;
    logic          udf;
    logic [DW-1:0] rd_q;
    logic [DW-1:0] mem [DEPTH];

`ifdef FIFO_PN_EDGE_SYNC_EN
    logic [3:0] wr_sync;
    logic [3:0] rd_sync;

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            wr_sync <= '0;
            rd_sync <= '0;
        end else begin
            wr_sync <= {wr_sync[2:0], bus.wr_req};
            rd_sync <= {rd_sync[2:0], bus.rd_req};
        end
    end

    // One strobe per access: old sample low, two newer samples high.
    assign wr_stb = (wr_sync[2:0] == 3'b011);
    assign rd_stb = (rd_sync[2:0] == 3'b011);
`else
    assign wr_stb = bus.wr_req;
    assign rd_stb = bus.rd_req;
`endif

    assign full        = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign level       = wr_ptr - rd_ptr;
    assign wr_acc      = wr_stb & ~full & ~bus.flush;
    assign rd_acc      = rd_stb & out_vld & ~bus.flush;
    assign set_ovf     = wr_stb & full & ~bus.flush;
    assign set_udf     = rd_stb & ~out_vld & ~bus.flush;
    assign rd_ptr_next = rd_acc ? rd_ptr + 1'b1 : rd_ptr;

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            out_vld <= 1'b0;
        end else if (bus.flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            out_vld <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            rd_ptr <= rd_ptr_next;
            // The head is valid only if it was already in RAM before this edge.
            out_vld <= (wr_ptr != rd_ptr_next);
        end
    end

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            ovf <= 1'b0;
            udf <= 1'b0;
        end else begin
            ovf <= set_ovf | (ovf & ~bus.clr_err);
            udf <= set_udf | (udf & ~bus.clr_err);
        end
    end

    always_ff @(negedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr[AW-1:0]] <= bus.wr_data;
        end
    end

    // Reading at the post-pop address gives zero-bubble back-to-back pops.
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            rd_q <= '0;
        end else begin
            rd_q <= mem[rd_ptr_next[AW-1:0]];
        end
    end

    assign bus.rd_data = rd_q;
    assign bus.empty   = ~out_vld;
    assign bus.full    = full;
    assign bus.afull   = (level >= AFULL_V);
    assign bus.level   = level;
    assign bus.ovf     = ovf;
    assign bus.udf     = udf;
endmodule

// File: tb/tb_fifo_pn.sv
// Randomised directed bench for fifo_pn against a queue model where an entry becomes readable one edge after it is written.
module tb_fifo_pn;
    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 16;
    localparam int AFL   = 12;

    typedef struct {
        logic [DW-1:0] d;
        int            e;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    fifo_pn_if #(.DW(DW), .AW(AW)) bus ();

    fifo_pn #(.DW(DW), .AW(AW), .AFULL_LVL(AFL)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int   n_vec = 0;
    int   n_err = 0;
    ent_t q[$];
    int   edge_n = 0;
    logic m_ovf = 1'b0;
    logic m_udf = 1'b0;
    logic m_empty = 1'b1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".level"}, 32'(bus.level), 32'(q.size()));
        chk({tag, ".empty"}, 32'(bus.empty), 32'(m_empty));
        chk({tag, ".full"},  32'(bus.full),  32'(q.size() == DEPTH));
        chk({tag, ".afull"}, 32'(bus.afull), 32'(q.size() >= AFL));
        chk({tag, ".ovf"},   32'(bus.ovf),   32'(m_ovf));
        chk({tag, ".udf"},   32'(bus.udf),   32'(m_udf));
        if (!m_empty) chk({tag, ".rd_data"}, 32'(bus.rd_data), 32'(q[0].d));
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".level"},   32'(bus.level),   32'd0);
        chk({tag, ".empty"},   32'(bus.empty),   32'd1);
        chk({tag, ".full"},    32'(bus.full),    32'd0);
        chk({tag, ".afull"},   32'(bus.afull),   32'd0);
        chk({tag, ".ovf"},     32'(bus.ovf),     32'd0);
        chk({tag, ".udf"},     32'(bus.udf),     32'd0);
        chk({tag, ".rd_data"}, 32'(bus.rd_data), 32'd0);
    endtask

    task automatic model_reset();
        q.delete();
        m_ovf   = 1'b0;
        m_udf   = 1'b0;
        m_empty = 1'b1;
    endtask

    // Drive one cycle of inputs, let the falling edge take them, update the model, then compare.
    task automatic tick(input logic wr, input logic rd, input logic fl, input logic clr,
                        input logic [DW-1:0] d, input string tag);
        logic wr_ok, rd_ok, s_ovf, s_udf;
        bus.wr_req  = wr;
        bus.rd_req  = rd;
        bus.flush   = fl;
        bus.clr_err = clr;
        bus.wr_data = d;
        @(negedge clk);
        edge_n++;
        s_ovf = 1'b0;
        s_udf = 1'b0;
        if (fl) begin
            q.delete();
        end else begin
            wr_ok = wr && (q.size() < DEPTH);
            rd_ok = rd && !m_empty;
            s_ovf = wr && !wr_ok;
            s_udf = rd && !rd_ok;
            if (rd_ok) void'(q.pop_front());
            if (wr_ok) q.push_back('{d: d, e: edge_n});
        end
        m_ovf   = s_ovf | (m_ovf & ~clr);
        m_udf   = s_udf | (m_udf & ~clr);
        m_empty = (q.size() == 0) || (q[0].e == edge_n);
        #1;
        check_all(tag);
    endtask

    task automatic idle(input string tag);
        tick(1'b0, 1'b0, 1'b0, 1'b0, '0, tag);
    endtask

    initial begin
        bus.wr_req  = 1'b0;
        bus.rd_req  = 1'b0;
        bus.flush   = 1'b0;
        bus.clr_err = 1'b0;
        bus.wr_data = '0;
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        #2;
        chk_reset("reset");
        rst = 1'b0;
        model_reset();

`ifdef FIFO_PN_EDGE_SYNC_EN
        bus.wr_data = 8'hA5;
        bus.wr_req  = 1'b1;
        repeat (10) begin
            @(negedge clk);
            #1;
            chk("sync_hold.level_le1", 32'(bus.level <= 1), 32'd1);
        end
        bus.wr_req = 1'b0;
        repeat (6) @(negedge clk);
        #1;
        chk("sync_hold.level", 32'(bus.level), 32'd1);
        chk("sync_hold.empty", 32'(bus.empty), 32'd0);
        chk("sync_hold.rd_data", 32'(bus.rd_data), 32'hA5);
        chk("sync_hold.ovf", 32'(bus.ovf), 32'd0);
`else
        // Three writes, then show-ahead reads with no bubbles and an underflow.
        tick(1'b1, 1'b0, 1'b0, 1'b0, 8'h11, "w11");
        chk("w11.empty_latency", 32'(bus.empty), 32'd1);
        tick(1'b1, 1'b0, 1'b0, 1'b0, 8'h22, "w22");
        chk("w22.rd_data", 32'(bus.rd_data), 32'h11);
        tick(1'b1, 1'b0, 1'b0, 1'b0, 8'h33, "w33");
        chk("w33.level", 32'(bus.level), 32'd3);
        idle("idle3");
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 1'b0, 1'b0, '0, "pop");
        chk("drain.empty", 32'(bus.empty), 32'd1);
        tick(1'b0, 1'b1, 1'b0, 1'b0, '0, "pop_udf");
        chk("pop_udf.udf", 32'(bus.udf), 32'd1);

        // Fill to full, overflow, then read back in order.
        tick(1'b0, 1'b0, 1'b0, 1'b1, '0, "clr1");
        for (int i = 0; i < DEPTH; i++) tick(1'b1, 1'b0, 1'b0, 1'b0, 8'($urandom), "fill");
        chk("fill.full", 32'(bus.full), 32'd1);
        tick(1'b1, 1'b0, 1'b0, 1'b0, 8'hEE, "w17");
        chk("w17.ovf", 32'(bus.ovf), 32'd1);
        chk("w17.level", 32'(bus.level), 32'd16);
        for (int i = 0; i < DEPTH; i++) tick(1'b0, 1'b1, 1'b0, 1'b0, '0, "readback");

        // Full FIFO with simultaneous write and read.
        tick(1'b0, 1'b0, 1'b0, 1'b1, '0, "clr2");
        for (int i = 0; i < DEPTH; i++) tick(1'b1, 1'b0, 1'b0, 1'b0, 8'($urandom), "fill2");
        idle("fill2_settle");
        tick(1'b1, 1'b1, 1'b0, 1'b0, 8'h5A, "full_wr_rd");
        chk("full_wr_rd.level", 32'(bus.level), 32'd15);
        chk("full_wr_rd.ovf", 32'(bus.ovf), 32'd1);

        // Mixed traffic across pointer wrap, then with flush/clr sprinkled in.
        for (int i = 0; i < 40; i++)
            tick(1'($urandom), 1'($urandom), 1'b0, 1'b0, 8'($urandom), "mixed");
        for (int i = 0; i < 200; i++)
            tick(($urandom_range(0, 2) != 0), 1'($urandom), ($urandom_range(0, 15) == 0),
                 ($urandom_range(0, 15) == 0), 8'($urandom), "rand");

        // Level 5 with ovf set, flush collides with a write, then clear errors.
        tick(1'b0, 1'b0, 1'b1, 1'b0, '0, "flush0");
        for (int i = 0; i < DEPTH + 1; i++) tick(1'b1, 1'b0, 1'b0, 1'b0, 8'($urandom), "fill3");
        idle("fill3_settle");
        for (int i = 0; i < 11; i++) tick(1'b0, 1'b1, 1'b0, 1'b0, '0, "down5");
        chk("down5.level", 32'(bus.level), 32'd5);
        tick(1'b1, 1'b0, 1'b1, 1'b0, 8'h77, "flush_wr");
        chk("flush_wr.level", 32'(bus.level), 32'd0);
        chk("flush_wr.empty", 32'(bus.empty), 32'd1);
        chk("flush_wr.ovf_kept", 32'(bus.ovf), 32'd1);
        idle("flush_idle");
        idle("flush_idle2");
        tick(1'b0, 1'b0, 1'b0, 1'b1, '0, "clr3");
        chk("clr3.ovf", 32'(bus.ovf), 32'd0);

        // Asynchronous reset in the middle of a burst.
        for (int i = 0; i < 6; i++) tick(1'b1, 1'($urandom), 1'b0, 1'b0, 8'($urandom), "burst");
        tick(1'b1, 1'b1, 1'b0, 1'b0, 8'h99, "udf_pre");
        rst = 1'b1;
        #1;
        chk_reset("async_rst");
        @(negedge clk);
        #2;
        rst = 1'b0;
        model_reset();
        tick(1'b0, 1'b0, 1'b0, 1'b0, '0, "post_rst");
        tick(1'b1, 1'b0, 1'b0, 1'b0, 8'h3C, "post_rst_w");
        idle("post_rst_idle");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
